// File: rtl/btn_event_queue_if.sv
// Downstream event port of btn_event_queue: a FIFO head presented over valid/ready,
// plus the current occupancy.
interface btn_event_queue_if #(
  parameter int IDX_W = 1,
  parameter int LVL_W = 3
);
  // Valid/ready: a transfer happens on a clock edge where ev_valid and ev_ready are
  // both high. Once ev_valid rises, ev_valid and ev_index stay stable until that
  // transfer. ev_valid never depends combinationally on ev_ready. ev_ready is
  // ignored while ev_valid is low.
  logic             ev_valid;
  logic             ev_ready;
  logic [IDX_W-1:0] ev_index;
  logic [LVL_W-1:0] ev_level;

  modport master (
    output ev_valid,
    output ev_index,
    output ev_level,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_index,
    input  ev_level,
    output ev_ready
  );
endinterface

// File: rtl/btn_event_queue_sync_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PTR_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[ADDR_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_W'(1);
      if (rd_en) rptr <= rptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/btn_event_queue.sv
// Turns debounced button levels into one press event per press, queues them in a
// small FIFO and presents them downstream over valid/ready.
module btn_event_queue #(
  parameter int                 WIDTH           = 2,
  parameter int                 DEPTH           = 4,
  parameter logic [WIDTH-1:0]   POLARITY_VECTOR = 2'b11,
  parameter int                 IDX_W           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  btn_event_queue_if.master ev,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] lowest;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] drop;
  logic [IDX_W-1:0] cand_idx;
  logic             cand_valid;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] fifo_rdata;
  logic [LVL_W-1:0] fifo_level;

  assign pressed    = din ~^ POLARITY_VECTOR;
  assign edge_vec   = pressed & ~prev;
  assign cand_valid = |pending;
  // Two's-complement trick isolates the lowest set pending bit as a one-hot mask.
  assign lowest     = pending & (~pending + WIDTH'(1));

  always_comb begin
    cand_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) cand_idx = IDX_W'(i);
    end
  end

  assign pop      = ~fifo_empty & ev.ev_ready;
  assign push     = cand_valid & (~fifo_full | pop);
  assign clr_mask = push ? lowest : '0;
  // A press on a bit that stays pending has nowhere to go; a bit being cleared
  // this cycle can simply be re-set by the new press.
  assign drop     = edge_vec & pending & ~clr_mask;

  always_ff @(posedge clk) begin
    prev <= pressed;
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | edge_vec;
      if (|drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (cand_idx),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign ev.ev_valid = ~fifo_empty;
  assign ev.ev_index = fifo_empty ? '0 : fifo_rdata;
  assign ev.ev_level = fifo_level;

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed bench for btn_event_queue: an active-high instance for the queueing,
// overflow and reset scenarios, and an active-low instance for polarity.
module tb_btn_event_queue;

  logic       clk;
  logic       rst;
  logic [1:0] din_hi;
  logic [1:0] din_lo;
  logic       clr_hi;
  logic       clr_lo;
  logic       ovf_hi;
  logic       ovf_lo;

  logic [0:0] exp_q[$];
  int         n_vec;
  int         n_miss;

  btn_event_queue_if #(.IDX_W(1), .LVL_W(3)) hi_if ();
  btn_event_queue_if #(.IDX_W(1), .LVL_W(3)) lo_if ();

  btn_event_queue #(
    .WIDTH(2), .DEPTH(4), .POLARITY_VECTOR(2'b11)
  ) dut_hi (
    .clk          (clk),
    .rst          (rst),
    .din          (din_hi),
    .ev           (hi_if),
    .overflow     (ovf_hi),
    .clr_overflow (clr_hi)
  );

  btn_event_queue #(
    .WIDTH(2), .DEPTH(4), .POLARITY_VECTOR(2'b00)
  ) dut_lo (
    .clk          (clk),
    .rst          (rst),
    .din          (din_lo),
    .ev           (lo_if),
    .overflow     (ovf_lo),
    .clr_overflow (clr_lo)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    hi_if.ev_ready = 1'b1;
    while (hi_if.ev_valid && n < max_cycles) begin
      if (exp_q.size() == 0) begin
        check("drain_extra_event", 1, 0);
      end else begin
        check("drain_index", hi_if.ev_index, exp_q.pop_front());
      end
      tick();
      n++;
    end
    hi_if.ev_ready = 1'b0;
    check("drain_timeout", (n < max_cycles), 1);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int cnt;
    int first;
    int idx;
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    din_hi = 2'b00;
    din_lo = 2'b11;
    clr_hi = 1'b0;
    clr_lo = 1'b0;
    hi_if.ev_ready = 1'b1;
    lo_if.ev_ready = 1'b1;

    // 1: reset state, single press with ready high
    ticks(3);
    check("rst_valid", hi_if.ev_valid, 0);
    check("rst_level", hi_if.ev_level, 0);
    check("rst_ovf", ovf_hi, 0);
    check("rst_lo_valid", lo_if.ev_valid, 0);
    rst = 1'b0;
    tick();
    din_hi = 2'b01;
    cnt = 0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (hi_if.ev_valid) begin
        cnt++;
        if (first == 0) first = i;
        check("t1_index", hi_if.ev_index, 0);
      end
    end
    check("t1_count", cnt, 1);
    check("t1_latency", first, 2);
    check("t1_ovf", ovf_hi, 0);
    din_hi = 2'b00;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (hi_if.ev_valid) cnt++;
    end
    check("t1_release", cnt, 0);

    // 2: simultaneous press, held off then drained in index order
    hi_if.ev_ready = 1'b0;
    din_hi = 2'b11;
    tick();
    check("t2_level_k", hi_if.ev_level, 0);
    tick();
    check("t2_level_1", hi_if.ev_level, 1);
    tick();
    check("t2_level_2", hi_if.ev_level, 2);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    drain(8);
    check("t2_level_end", hi_if.ev_level, 0);
    din_hi = 2'b00;
    tick();

    // 3: fill to DEPTH, fifth press waits, then same-cycle push+pop
    din_hi = 2'b01; tick(); exp_q.push_back(1'b0);
    din_hi = 2'b10; tick(); exp_q.push_back(1'b1);
    din_hi = 2'b01; tick(); exp_q.push_back(1'b0);
    din_hi = 2'b10; tick(); exp_q.push_back(1'b1);
    ticks(3);
    check("t3_full_level", hi_if.ev_level, 4);
    check("t3_ovf", ovf_hi, 0);
    din_hi = 2'b01;
    ticks(2);
    check("t3_wait_level", hi_if.ev_level, 4);
    check("t3_wait_ovf", ovf_hi, 0);
    check("t3_head_valid", hi_if.ev_valid, 1);
    hi_if.ev_ready = 1'b1;
    check("t3_pop_index", hi_if.ev_index, exp_q.pop_front());
    tick();
    hi_if.ev_ready = 1'b0;
    exp_q.push_back(1'b0);
    check("t3_pushpop_level", hi_if.ev_level, 4);
    check("t3_new_head", hi_if.ev_index, exp_q[0]);

    // 4: overflow set, sticky, cleared, set beats clear
    din_hi = 2'b10;
    tick();
    check("t4_pending_ovf", ovf_hi, 0);
    din_hi = 2'b00; tick();
    din_hi = 2'b10; tick();
    check("t4_drop_ovf", ovf_hi, 1);
    ticks(2);
    check("t4_sticky_ovf", ovf_hi, 1);
    clr_hi = 1'b1; tick();
    clr_hi = 1'b0;
    check("t4_clr_ovf", ovf_hi, 0);
    din_hi = 2'b00; tick();
    din_hi = 2'b10;
    clr_hi = 1'b1; tick();
    clr_hi = 1'b0;
    check("t4_set_beats_clr", ovf_hi, 1);
    exp_q.push_back(1'b1);
    drain(20);
    check("t4_level_end", hi_if.ev_level, 0);
    clr_hi = 1'b1; tick();
    clr_hi = 1'b0;
    din_hi = 2'b00; tick();

    // 5: button held through reset, then reset mid-stream
    rst = 1'b1;
    din_hi = 2'b10;
    ticks(2);
    rst = 1'b0;
    ticks(3);
    check("t5_held_valid", hi_if.ev_valid, 0);
    check("t5_held_level", hi_if.ev_level, 0);
    din_hi = 2'b00; tick();
    din_hi = 2'b01; tick();
    din_hi = 2'b10; tick();
    din_hi = 2'b01; tick();
    tick();
    check("t5_queued_level", hi_if.ev_level, 3);
    rst = 1'b1;
    tick();
    check("t5_rst_valid", hi_if.ev_valid, 0);
    check("t5_rst_level", hi_if.ev_level, 0);
    rst = 1'b0;
    tick();
    check("t5_post_valid", hi_if.ev_valid, 0);
    check("t5_post_level", hi_if.ev_level, 0);
    ticks(2);
    check("t5_no_event", hi_if.ev_valid, 0);
    exp_q.delete();
    din_hi = 2'b00;
    tick();

    // 6: active-low instance
    check("t6_idle_valid", lo_if.ev_valid, 0);
    check("t6_idle_level", lo_if.ev_level, 0);
    din_lo = 2'b01;
    cnt = 0;
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (lo_if.ev_valid) begin
        cnt++;
        idx = int'(lo_if.ev_index);
      end
    end
    check("t6_count", cnt, 1);
    check("t6_index", idx, 1);
    din_lo = 2'b11;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (lo_if.ev_valid) cnt++;
    end
    check("t6_release", cnt, 0);
    check("t6_ovf", ovf_lo, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/btn_event_queue.md
Name: btn_event_queue

Overview:
- Sits between the button debouncer and the UART message transmitter.
- Turns debounced button levels into discrete press events, one per button press.
- Buffers events in a small FIFO and hands them downstream over a valid/ready handshake, so presses arriving during a message transmission are not lost.
- Drops an event only when its button already has an event pending, and flags the drop on a sticky overflow output.

Parameters:
- WIDTH, 2, number of button inputs.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- POLARITY_VECTOR, 2'b11, per-bit press level: 1 means active-high, 0 means active-low.
- IDX_W, $clog2(WIDTH) (minimum 1), width of the event index.

Ports:
- clk  in  1  system clock (12 MHz).
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  debounced button levels, already synchronous to clk.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head this cycle.
- ev_index  out  IDX_W  button index of the head event.
- ev_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: an event was dropped.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Normalisation: pressed[i] = din[i] ~^ POLARITY_VECTOR[i].
- Edge detect: prev register; edge[i] = pressed[i] & ~prev[i]. Only presses generate events, never releases.
- Reset behaviour:
  - While rst is high, prev <= pressed, so a button held through reset produces no event on release of rst.
  - pending, FIFO pointers, ev_valid, overflow and ev_level all reset to 0.
  - ev_index resets to 0.
- Pending mask (WIDTH bits):
  - An edge at clock edge k sets pending[i] at edge k.
  - If pending[i] is already set and not being cleared in the same cycle, the new edge is dropped and overflow <= 1.
- Push selection:
  - Each cycle, the lowest-index set pending bit is the push candidate.
  - It is written to the FIFO at the next edge if the FIFO is not full, or if it is full and a pop occurs the same cycle.
  - The written bit is then cleared from pending.
  - If a new edge on the same bit arrives in the same cycle as its clear, set wins: the bit stays pending and no overflow is flagged.
- Latency: din change sampled at edge k -> pending at k -> FIFO write at k+1 -> ev_valid high after edge k+1. Two cycles, empty FIFO.
- FIFO:
  - Pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - Read and write addresses wrap modulo DEPTH.
  - ev_index is driven combinationally from the head entry; it is a don't-care when ev_valid is 0. The bench ignores it then.
  - Pop occurs when ev_valid & ev_ready.
  - ev_level increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- Full FIFO: candidates wait in pending; nothing is lost until the same button presses again.
- Empty FIFO: ev_ready is ignored, no pointer movement.
- Handshake rule: ev_valid and ev_index hold stable until accepted. No combinational path from ev_ready to ev_valid.
- overflow: set has priority over clr_overflow in the same cycle.
- Reset mid-operation: all queued and pending events are discarded; the cycle after rst deasserts, ev_valid = 0.

Decomposition:
- No package. Polarity and width travel as parameters, matching the existing debouncer/uart_tx parameter names.
- One sub-module, sync_fifo (WIDTH=IDX_W, DEPTH):
  - push/pop/full/empty/level interface, synchronous rst.
  - Reusable by other buffered stages.
- Edge detect, pending mask and priority select stay in btn_event_queue.

Test Plan:
1. Single press, active-high, ev_ready=1: rst 3 cycles, then din=2'b01 held 10 cycles -> ev_valid high exactly one cycle, 2 cycles after the din edge, ev_index=0, overflow=0. Release din -> no event.
2. Simultaneous press, ev_ready=0: din 2'b00->2'b11 -> ev_level goes 1 then 2; the events pop in order index 0 then 1 when ev_ready=1.
3. Fill and back-pressure, ev_ready=0, DEPTH=4: alternate presses btn0, btn1, btn0, btn1 -> level=4. A fifth press of btn0 stays pending with no overflow. One pop -> the pending event enters the FIFO in the same-cycle push+pop, level stays 4.
4. Overflow: with FIFO full and btn1 pending, press btn1 again -> overflow=1 and stays set. clr_overflow pulse -> 0. Coincident new drop plus clr -> overflow remains 1.
5. Reset behaviour: hold din=2'b10 through rst, deassert rst -> no event. Queue 3 events, assert rst mid-stream -> ev_valid=0 and level=0 on the next cycle.
6. Active-low, POLARITY_VECTOR=2'b00: din idles 2'b11, drop bit1 to 0 -> one event with ev_index=1. Return to 1 -> none.
